// File: rtl/des_key_schedule_control.sv
// DES key schedule sequencer: captures the key, applies PC-1 and steps
// des_key_generator through load plus 16 encryption rounds with ack handshake.
module des_key_schedule_control #(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_din,
  input  logic [63:0] key_din,
  input  logic        round_ack_din,
  output logic        ready_dout,
  output logic [55:0] parity_drop_key_dout,
  output logic        enable_dout,
  output logic        source_sel_dout,
  output logic        round_shift_dout,
  output logic        round_valid_dout,
  output logic [3:0]  round_index_dout,
  output logic        last_round_dout,
  output logic        done_dout,
  output logic        parity_error_dout
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROUND,
    DONE
  } state_t;

  // PC-1 positions, 1-based, bit 1 = MSB of the key
  localparam logic [6:0] PC1 [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  state_t      state;
  logic [63:0] key_reg;
  logic [3:0]  cnt;
  logic        ready_q;
  logic        load_q;
  logic        src_q;
  logic        shift_q;
  logic        valid_q;
  logic        last_q;
  logic        done_q;
  logic        perr_q;

  function automatic logic shift_of(input logic [3:0] c);
    unique case (c)
      4'd0, 4'd1, 4'd8, 4'd15: shift_of = 1'b0;
      default:                 shift_of = 1'b1;
    endcase
  endfunction

  function automatic logic any_even(input logic [63:0] k);
    logic r;
    r = 1'b0;
    for (int b = 0; b < 8; b++)
      r = r | ~(^k[8*b +: 8]);
    return r;
  endfunction

  always_comb begin
    parity_drop_key_dout = '0;
    for (int i = 0; i < 56; i++)
      parity_drop_key_dout[55-i] =
        key_reg[6'(7'd64 - PC1[i])];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      key_reg <= '0;
      cnt     <= '0;
      ready_q <= 1'b1;
      load_q  <= 1'b0;
      src_q   <= 1'b0;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_din) begin
            key_reg <= key_din;
            cnt     <= '0;
            perr_q  <= CHECK_PARITY & any_even(key_din);
            ready_q <= 1'b0;
            load_q  <= 1'b1;
            src_q   <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          load_q  <= 1'b0;
          valid_q <= 1'b1;
          src_q   <= 1'b1;
          shift_q <= shift_of(4'd0);
          last_q  <= 1'b0;
          state   <= ROUND;
        end
        ROUND: begin
          if (round_ack_din) begin
            if (cnt == 4'd15) begin
              valid_q <= 1'b0;
              src_q   <= 1'b0;
              shift_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end else begin
              cnt     <= cnt + 4'd1;
              shift_q <= shift_of(cnt + 4'd1);
              last_q  <= (cnt + 4'd1) == 4'd15;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          cnt     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // generator advances on the ack edge itself, hence combinational
  assign enable_dout       = load_q | (valid_q & round_ack_din);
  assign ready_dout        = ready_q;
  assign source_sel_dout   = src_q;
  assign round_shift_dout  = shift_q;
  assign round_valid_dout  = valid_q;
  assign round_index_dout  = cnt;
  assign last_round_dout   = last_q;
  assign done_dout         = done_q;
  assign parity_error_dout = perr_q;

endmodule

// File: tb/tb_des_key_schedule_control.sv
// Bench for des_key_schedule_control with a behavioural key generator
// and a round-key scoreboard fed from a reference DES schedule.
module tb_des_key_schedule_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_din = 1'b0;
  logic [63:0] key_din = '0;
  logic        round_ack_din = 1'b0;
  logic        ready_dout;
  logic [55:0] parity_drop_key_dout;
  logic        enable_dout;
  logic        source_sel_dout;
  logic        round_shift_dout;
  logic        round_valid_dout;
  logic [3:0]  round_index_dout;
  logic        last_round_dout;
  logic        done_dout;
  logic        parity_error_dout;

  always #5 clk = ~clk;

  des_key_schedule_control #(.CHECK_PARITY(1'b1)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start_din            (start_din),
    .key_din              (key_din),
    .round_ack_din        (round_ack_din),
    .ready_dout           (ready_dout),
    .parity_drop_key_dout (parity_drop_key_dout),
    .enable_dout          (enable_dout),
    .source_sel_dout      (source_sel_dout),
    .round_shift_dout     (round_shift_dout),
    .round_valid_dout     (round_valid_dout),
    .round_index_dout     (round_index_dout),
    .last_round_dout      (last_round_dout),
    .done_dout            (done_dout),
    .parity_error_dout    (parity_error_dout)
  );

  int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
  };
  int PC2_T [48] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  logic [15:0] shift_tab = 16'h7EFC;

  localparam logic [63:0] KA = 64'h133457799BBCDFF1;
  localparam logic [63:0] KB = 64'h133457799BBCDFF0;

  typedef struct packed {
    logic [3:0]  idx;
    logic [47:0] key;
  } sb_t;

  sb_t sb_q[$];
  sb_t e;
  int  n_tests = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
    return (x << n) | (x >> (28 - n));
  endfunction

  task automatic push_expected(input logic [63:0] k);
    logic [55:0] pd;
    logic [27:0] c, d;
    pd = pc1(k);
    c = pd[55:28];
    d = pd[27:0];
    for (int r = 0; r < 16; r++) begin
      c = rotl(c, SH_T[r]);
      d = rotl(d, SH_T[r]);
      sb_q.push_back({4'(r), pc2({c, d})});
    end
  endtask

  // behavioural des_key_generator driven by the DUT controls
  logic [27:0] gc, gd;
  logic [47:0] gen_key;
  always @(posedge clk) begin
    if (reset) begin
      gc <= '0;
      gd <= '0;
    end else if (enable_dout) begin
      if (!source_sel_dout) begin
        gc <= parity_drop_key_dout[55:28];
        gd <= parity_drop_key_dout[27:0];
      end else begin
        gc <= rotl(gc, round_shift_dout ? 2 : 1);
        gd <= rotl(gd, round_shift_dout ? 2 : 1);
      end
    end
  end
  always_comb
    gen_key = pc2({rotl(gc, round_shift_dout ? 2 : 1),
                   rotl(gd, round_shift_dout ? 2 : 1)});

  logic        prev_stall = 1'b0;
  logic [3:0]  p_idx;
  logic        p_sh;
  logic [47:0] p_key;
  logic [47:0] k1_seen, k16_seen;

  always @(negedge clk) begin
    if (!reset && round_valid_dout) begin
      if (prev_stall) begin
        chk("hold_idx", round_index_dout, p_idx);
        chk("hold_shift", round_shift_dout, p_sh);
        chk("hold_key", gen_key, p_key);
      end
      chk("shift_seq", round_shift_dout, shift_tab[round_index_dout]);
      chk("last_round", last_round_dout, round_index_dout == 4'd15);
      if (round_ack_din) begin
        chk("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("round_idx", round_index_dout, e.idx);
          chk("round_key", gen_key, e.key);
        end
        if (round_index_dout == 4'd0) k1_seen = gen_key;
        if (round_index_dout == 4'd15) k16_seen = gen_key;
      end
      prev_stall = !round_ack_din;
      p_idx = round_index_dout;
      p_sh = round_shift_dout;
      p_key = gen_key;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_sched(input logic [63:0] k, input int stall_max,
                           input int poke_idx, input int rst_idx,
                           output int lat, output logic perr_done);
    int stall;
    bit fin;
    push_expected(k);
    start_din = 1'b1;
    key_din = k;
    @(posedge clk);
    #1;
    start_din = 1'b0;
    key_din = ~k;
    lat = -1;
    perr_done = 1'b0;
    stall = 0;
    fin = 1'b0;
    for (int c = 1; c <= 300 && !fin; c++) begin
      if (rst_idx >= 0 && round_valid_dout &&
          round_index_dout == 4'(rst_idx)) begin
        round_ack_din = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mid_ready", ready_dout, 1'b1);
        chk("rst_mid_valid", round_valid_dout, 1'b0);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          chk("rst_mid_nodone", done_dout, 1'b0);
        end
        sb_q.delete();
        fin = 1'b1;
      end else begin
        if (poke_idx >= 0 && round_valid_dout &&
            round_index_dout == 4'(poke_idx)) begin
          start_din = 1'b1;
          key_din = 64'h0123456789ABCDEF;
        end else begin
          start_din = 1'b0;
        end
        if (stall > 0) begin
          round_ack_din = 1'b0;
          stall--;
        end else begin
          round_ack_din = 1'b1;
          if (stall_max > 0) stall = $urandom_range(0, stall_max);
        end
        @(negedge clk);
        if (done_dout) begin
          lat = c;
          perr_done = parity_error_dout;
          fin = 1'b1;
        end
        @(posedge clk);
        #1;
      end
    end
    start_din = 1'b0;
    round_ack_din = 1'b0;
    if (rst_idx < 0) begin
      chk("done_seen", lat != -1, 1'b1);
      chk("ready_after", ready_dout, 1'b1);
      chk("done_pulse", done_dout, 1'b0);
    end
  endtask

  int   lat;
  logic perr;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ready", ready_dout, 1'b1);
    chk("rst_outs", {enable_dout, source_sel_dout, round_shift_dout,
                     round_valid_dout, last_round_dout, done_dout,
                     parity_error_dout}, 7'd0);
    chk("rst_index", round_index_dout, 4'd0);
    chk("rst_pd", parity_drop_key_dout, 56'd0);

    run_sched(KA, 0, -1, -1, lat, perr);
    chk("pd_a", parity_drop_key_dout, 56'hF0CCAAF556678F);
    chk("lat_a", lat, 18);
    chk("perr_a", perr, 1'b0);
    chk("k1_a", k1_seen, 48'h1B02EFFC7072);
    chk("k16_a", k16_seen, 48'hCB3D8B0E17F5);
    chk("gen_wrap", {gc, gd}, parity_drop_key_dout);

    k1_seen = '0;
    k16_seen = '0;
    run_sched(KA, 7, -1, -1, lat, perr);
    chk("k1_stall", k1_seen, 48'h1B02EFFC7072);
    chk("k16_stall", k16_seen, 48'hCB3D8B0E17F5);
    chk("sb_drained", sb_q.size(), 0);

    k1_seen = '0;
    run_sched(KB, 0, -1, -1, lat, perr);
    chk("perr_bad", perr, 1'b1);
    chk("k1_bad", k1_seen, 48'h1B02EFFC7072);
    run_sched(KA, 0, -1, -1, lat, perr);
    chk("perr_clear", perr, 1'b0);

    k16_seen = '0;
    run_sched(KA, 2, 4, -1, lat, perr);
    chk("k16_poke", k16_seen, 48'hCB3D8B0E17F5);
    chk("pd_poke", parity_drop_key_dout, 56'hF0CCAAF556678F);

    run_sched(KA, 0, -1, 6, lat, perr);
    k16_seen = '0;
    run_sched(KA, 0, -1, -1, lat, perr);
    chk("lat_after_rst", lat, 18);
    chk("k16_after_rst", k16_seen, 48'hCB3D8B0E17F5);
    chk("sb_final", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
